// File: rtl/bitnot_sched.sv
// Two-requester round-robin scheduler feeding a one-deep output register that
// holds the width-extended, bitwise-inverted operand of the accepted requester.
module bitnot_sched #(
    parameter int W  = 16,
    parameter int CW = 16,
    localparam int WW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_data,
    input  logic [WW-1:0] req0_width,
    input  logic          req0_signed,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_data,
    input  logic [WW-1:0] req1_width,
    input  logic          req1_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_src,
    output logic [CW-1:0] gnt0_cnt,
    output logic [CW-1:0] gnt1_cnt
);

    localparam logic [WW-1:0] WMAX = WW'(W);
    localparam logic [W-1:0]  ONES = '1;
    localparam logic [CW-1:0] CMAX = '1;

    logic          last_gnt;
    logic          can_accept;
    logic          pick1;
    logic          acc0;
    logic          acc1;
    logic [W-1:0]  sel_data;
    logic [WW-1:0] sel_width;
    logic          sel_signed;

    function automatic logic [W-1:0] bitnot_ext(input logic [W-1:0]  d,
                                                input logic [WW-1:0] wd,
                                                input logic          sgn);
        logic [WW-1:0] n;
        logic [W-1:0]  mask;
        logic [W-1:0]  top;
        logic [W-1:0]  ext;
        // Width 0 or anything wider than the datapath means full width.
        n    = (wd == '0 || wd > WMAX) ? WMAX : wd;
        mask = ONES >> (WMAX - n);
        top  = d >> (n - WW'(1));
        ext  = d & mask;
        if (sgn && top[0]) begin
            ext = ext | ~mask;
        end
        return ~ext;
    endfunction

    always_comb begin
        can_accept = rst_n && (!out_valid || out_ready);
        // last_gnt is the index of the most recent accepted requester.
        pick1      = req1_valid && (!req0_valid || !last_gnt);
        req1_ready = can_accept && pick1;
        req0_ready = can_accept && req0_valid && !pick1;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        sel_data   = acc1 ? req1_data   : req0_data;
        sel_width  = acc1 ? req1_width  : req0_width;
        sel_signed = acc1 ? req1_signed : req0_signed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            last_gnt  <= 1'b1;
            gnt0_cnt  <= '0;
            gnt1_cnt  <= '0;
        end else begin
            if (acc0 || acc1) begin
                out_valid <= 1'b1;
                out_data  <= bitnot_ext(sel_data, sel_width, sel_signed);
                out_src   <= acc1;
                last_gnt  <= acc1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc0 && gnt0_cnt != CMAX) begin
                gnt0_cnt <= gnt0_cnt + CW'(1);
            end
            if (acc1 && gnt1_cnt != CMAX) begin
                gnt1_cnt <= gnt1_cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/bitnot_sched.md
BITNOT_SCHED -- requirements
Module: bitnot_sched

Interface
Parameters:
REQ-001 W, default 16, meaning maximum operand width in bits (legal range 2..64).
REQ-002 CW, default 16, meaning width of each per-requester grant counter.
Ports (name  direction  width  meaning):
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid  input  1  requester 0 has an operand.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle when high with req0_valid.
REQ-007 req0_data  input  W  requester 0 operand.
REQ-008 req0_width  input  $clog2(W+1)  requester 0 effective width; 0 or >W means W.
REQ-009 req0_signed  input  1  requester 0 operand is signed (sign-extend) when high, else zero-extend.
REQ-010 req1_valid, req1_ready, req1_data, req1_width, req1_signed  same directions/widths/meanings for requester 1.
REQ-011 out_valid  output  1  result held in output stage.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  W  inverted, extended operand.
REQ-014 out_src  output  1  requester index that produced out_data.
REQ-015 gnt0_cnt, gnt1_cnt  output  CW each  accepted-transfer counts per requester.

Function
REQ-016 Datapath: take low n bits of data (n = effective width), extend to W (sign bit n-1 if signed, else zeros), then bitwise invert all W bits.
REQ-017 Output stage is one register; result appears on out_data with out_valid high the cycle after acceptance (latency 1).
REQ-018 Stage can accept when out_valid low, or out_valid and out_ready both high (same-cycle drain and refill, no bubble).
REQ-019 Arbiter: round-robin, 1-bit last-grant pointer; if both valid, grant the requester not last granted; if one valid, grant it.
REQ-020 reqN_ready is high only for the granted requester and only when the stage can accept; the other ready is low; readies never both high.
REQ-021 reqN_ready does not depend on reqN_valid of the same requester beyond arbitration (no combinational loop through out_ready to valid).
REQ-022 Pointer updates only on an accepted transfer (valid & ready); unaccepted grants do not move it.
REQ-023 While out_valid high and out_ready low, out_data, out_src, out_valid hold stable.
REQ-024 Requester may change data/width/signed only after acceptance; inputs sampled only at acceptance edge.
REQ-025 gnt0_cnt/gnt1_cnt increment by 1 on each accepted transfer of that requester and saturate at all-ones (no wrap).
REQ-026 No requester waits more than one accepted transfer of the other while continuously valid.

Reset
REQ-027 On rst_n low, immediately: out_valid=0, out_data=0, out_src=0, gnt0_cnt=0, gnt1_cnt=0, pointer=1 (requester 0 wins first contention).
REQ-028 While rst_n low, req0_ready and req1_ready are 0.
REQ-029 Reset mid-transfer discards the held result; no output appears after deassertion until a new acceptance.
REQ-030 First acceptance possible on the first rising edge after rst_n deasserts.

Verification (W=16)
REQ-031 req0 data=0x0005 width=3 unsigned, out_ready=1 -> next cycle out_data=0xFFFA, out_src=0, gnt0_cnt=1.
REQ-032 req1 data=0x0005 width=3 signed -> out_data=0x0002, out_src=1.
REQ-033 req0 data=0x00FF width=0 unsigned -> width treated as 16, out_data=0xFF00.
REQ-034 Both valid continuously from reset, out_ready=1 -> out_src sequence 0,1,0,1; one result per cycle.
REQ-035 out_valid=1, out_ready held 0 for 3 cycles -> out_data stable, both readies 0, counters unchanged; out_ready=1 -> drain and refill same cycle.
REQ-036 rst_n pulsed low while out_valid=1 -> out_valid=0 immediately, counters 0, next contention grants requester 0.
